// File: rtl/lap_alarm_unit_pkg.sv
// lap_alarm_unit_pkg
//   Shared types and constants for the lap/alarm unit:
//   alarm FSM state enum, parameter defaults and the BCD digit width.
package lap_alarm_unit_pkg;

    localparam int BCD_W          = 4;
    localparam int ALARM_SECS_DEF = 6;
    localparam int LAP_DEPTH_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } alarm_state_e;

endpackage

// File: rtl/lap_alarm_unit_rise_detect.sv
// rise_detect
//   1-bit registered rising-edge detector.
//   Ports: clk_1s (clock), reset (sync, active-high), din (level input),
//          rise (din & ~previous din).
//   The history flop loads din even during reset, so a level already high
//   when reset releases never looks like an edge.
module rise_detect (
    input  logic clk_1s,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    // reset is deliberately not used to clear the history: it must track din
    always_comb begin
        din_d = din;
    end

    always_ff @(posedge clk_1s) begin
        din_q <= din_d;
    end

    assign rise = din & ~din_q;

    logic unused_reset;
    assign unused_reset = reset;

endmodule

// File: rtl/lap_alarm_unit.sv
// lap_alarm_unit
//   Extends an upstream 00-99 BCD seconds timer with a hundreds digit,
//   a timed alarm that rings after every 99->00 wrap, and a 4-slot lap store.
//   Ports:
//     clk_1s, reset            1 Hz clock, synchronous active-high reset
//     cnt_lo, cnt_hi, is_end   upstream BCD digits and wrap flag
//     lap_req, lap_clr         lap capture (rising edge) / store clear (level)
//     lap_sel                  slot shown on lap_hund/lap_hi/lap_lo
//     hundreds                 BCD count of completed 100-s periods
//     alarm, blink             alarm active and its display blink phase
//     lap_valid, lap_count, lap_full   lap store status
module lap_alarm_unit
    import lap_alarm_unit_pkg::*;
#(
    parameter int ALARM_SECS = ALARM_SECS_DEF,
    parameter int LAP_DEPTH  = LAP_DEPTH_DEF
) (
    input  logic             clk_1s,
    input  logic             reset,
    input  logic [BCD_W-1:0] cnt_lo,
    input  logic [BCD_W-1:0] cnt_hi,
    input  logic             is_end,
    input  logic             lap_req,
    input  logic             lap_clr,
    input  logic [1:0]       lap_sel,
    output logic [BCD_W-1:0] hundreds,
    output logic             alarm,
    output logic             blink,
    output logic [BCD_W-1:0] lap_hund,
    output logic [BCD_W-1:0] lap_hi,
    output logic [BCD_W-1:0] lap_lo,
    output logic             lap_valid,
    output logic [2:0]       lap_count,
    output logic             lap_full
);

    localparam logic [3:0] SECS_LAST = 4'(ALARM_SECS - 1);
    localparam logic [2:0] DEPTH_C   = 3'(LAP_DEPTH);
    localparam int         LAP_W     = 3 * BCD_W;

    logic end_rise;
    logic lap_rise;

    rise_detect u_end_rise (
        .clk_1s (clk_1s),
        .reset  (reset),
        .din    (is_end),
        .rise   (end_rise)
    );

    rise_detect u_lap_rise (
        .clk_1s (clk_1s),
        .reset  (reset),
        .din    (lap_req),
        .rise   (lap_rise)
    );

    // ---------------- hundreds digit ----------------
    logic [BCD_W-1:0] hundreds_q, hundreds_d;

    always_comb begin
        hundreds_d = hundreds_q;
        if (end_rise) begin
            hundreds_d = (hundreds_q == 4'd9) ? 4'd0 : hundreds_q + 4'd1;
        end
    end

    // ---------------- alarm FSM ----------------
    alarm_state_e state_q, state_d;
    logic [3:0]   secs_q, secs_d;
    logic         alarm_q, alarm_d;
    logic         blink_q, blink_d;

    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        alarm_d = alarm_q;
        blink_d = blink_q;
        case (state_q)
            IDLE: begin
                alarm_d = 1'b0;
                blink_d = 1'b0;
                if (end_rise) begin
                    state_d = RING;
                    secs_d  = 4'd0;
                    alarm_d = 1'b1;
                    blink_d = 1'b1;
                end
            end
            RING: begin
                if (end_rise) begin
                    // retrigger restarts the full alarm period
                    secs_d  = 4'd0;
                    blink_d = 1'b1;
                end else if (secs_q == SECS_LAST) begin
                    state_d = IDLE;
                    secs_d  = 4'd0;
                    alarm_d = 1'b0;
                    blink_d = 1'b0;
                end else begin
                    secs_d  = secs_q + 4'd1;
                    blink_d = ~blink_q;
                end
            end
            default: begin
                state_d = IDLE;
                secs_d  = 4'd0;
                alarm_d = 1'b0;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1s) begin
        if (reset) begin
            state_q <= IDLE;
            secs_q  <= 4'd0;
            alarm_q <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            alarm_q <= alarm_d;
            blink_q <= blink_d;
        end
    end

    // ---------------- lap store ----------------
    logic [LAP_DEPTH-1:0][LAP_W-1:0] slot_q, slot_d;
    logic [2:0]                      lap_count_q, lap_count_d;

    always_comb begin
        slot_d      = slot_q;
        lap_count_d = lap_count_q;
        if (lap_clr) begin
            lap_count_d = 3'd0;
        end else if (lap_rise && (lap_count_q < DEPTH_C)) begin
            // hundreds_q is the pre-edge value even if end_rise fires now
            slot_d[lap_count_q[1:0]] = {hundreds_q, cnt_hi, cnt_lo};
            lap_count_d              = lap_count_q + 3'd1;
        end
    end

    always_ff @(posedge clk_1s) begin
        if (reset) begin
            hundreds_q  <= '0;
            lap_count_q <= 3'd0;
            slot_q      <= '0;
        end else begin
            hundreds_q  <= hundreds_d;
            lap_count_q <= lap_count_d;
            slot_q      <= slot_d;
        end
    end

    // ---------------- outputs ----------------
    logic [LAP_W-1:0] lap_word;

    assign lap_valid = ({1'b0, lap_sel} < lap_count_q);
    assign lap_word  = lap_valid ? slot_q[lap_sel] : '0;

    assign lap_hund  = lap_word[3*BCD_W-1:2*BCD_W];
    assign lap_hi    = lap_word[2*BCD_W-1:BCD_W];
    assign lap_lo    = lap_word[BCD_W-1:0];
    assign lap_count = lap_count_q;
    assign lap_full  = (lap_count_q == DEPTH_C);
    assign hundreds  = hundreds_q;
    assign alarm     = alarm_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_lap_alarm_unit.sv
module tb_lap_alarm_unit;

    localparam int ALARM = 6;

    logic       clk_1s = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt_lo = '0, cnt_hi = '0;
    logic       is_end = 1'b0, lap_req = 1'b0, lap_clr = 1'b0;
    logic [1:0] lap_sel = '0;
    logic [3:0] hundreds, lap_hund, lap_hi, lap_lo;
    logic       alarm, blink, lap_valid, lap_full;
    logic [2:0] lap_count;

    int n_tests = 0;
    int n_fail  = 0;

    lap_alarm_unit #(.ALARM_SECS(ALARM), .LAP_DEPTH(4)) dut (
        .clk_1s   (clk_1s),
        .reset    (reset),
        .cnt_lo   (cnt_lo),
        .cnt_hi   (cnt_hi),
        .is_end   (is_end),
        .lap_req  (lap_req),
        .lap_clr  (lap_clr),
        .lap_sel  (lap_sel),
        .hundreds (hundreds),
        .alarm    (alarm),
        .blink    (blink),
        .lap_hund (lap_hund),
        .lap_hi   (lap_hi),
        .lap_lo   (lap_lo),
        .lap_valid(lap_valid),
        .lap_count(lap_count),
        .lap_full (lap_full)
    );

    always #5 clk_1s = ~clk_1s;

    // Reference model: elapsed-seconds view of the alarm and a queue of laps.
    logic [3:0]  m_hund = '0;
    bit          m_ring = 0;
    int          m_el   = 0;
    bit          m_pend = 0, m_preq = 0;
    logic [11:0] m_laps[$];

    task automatic model_edge();
        bit er, lr;
        if (reset) begin
            m_hund = '0; m_ring = 0; m_el = 0;
            m_laps.delete();
        end else begin
            er = is_end && !m_pend;
            lr = lap_req && !m_preq;
            if (lap_clr) m_laps.delete();
            else if (lr && m_laps.size() < 4) m_laps.push_back({m_hund, cnt_hi, cnt_lo});
            if (er) m_hund = 4'((m_hund + 1) % 10);
            if (er) begin
                m_ring = 1; m_el = 0;
            end else if (m_ring) begin
                m_el++;
                if (m_el == ALARM) begin m_ring = 0; m_el = 0; end
            end
        end
        m_pend = is_end;
        m_preq = lap_req;
    endtask

    task automatic tick();
        @(posedge clk_1s);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; is_end = 0; lap_req = 0; lap_clr = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({hundreds, alarm, blink, lap_count, lap_full, lap_valid} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset: got hund=%0d alarm=%b blink=%b cnt=%0d full=%b valid=%b, need all 0",
                     hundreds, alarm, blink, lap_count, lap_full, lap_valid);
        end
    endtask

    task automatic test_alarm();
        do_reset();
        is_end = 1; tick();
        n_tests++;
        if (hundreds !== 4'd1 || alarm !== 1'b1 || blink !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_start: got hund=%0d alarm=%b blink=%b, need 1 1 1", hundreds, alarm, blink);
        end
        is_end = 0;
        for (int i = 1; i < 9; i++) begin
            tick();
            n_tests++;
            if (alarm !== (i < ALARM) || blink !== (i < ALARM && i % 2 == 0)) begin
                n_fail++;
                $display("FAIL alarm_seq[%0d]: got alarm=%b blink=%b, need %b %b",
                         i, alarm, blink, i < ALARM, (i < ALARM && i % 2 == 0));
            end
        end
    endtask

    task automatic test_retrigger();
        int highs = 0;
        do_reset();
        is_end = 1; tick(); is_end = 0;
        tick(); tick(); tick();
        is_end = 1; tick(); is_end = 0;
        if (alarm) highs++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (alarm) highs++;
        end
        n_tests++;
        if (highs !== ALARM || hundreds !== 4'd2) begin
            n_fail++;
            $display("FAIL retrigger: got highs=%0d hund=%0d, need %0d 2", highs, hundreds, ALARM);
        end
    endtask

    task automatic test_hundreds_wrap();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            is_end = 1; tick();
            n_tests++;
            if (hundreds !== 4'(i % 10)) begin
                n_fail++;
                $display("FAIL hund_wrap[%0d]: got %0d, need %0d", i, hundreds, i % 10);
            end
            is_end = 0; tick();
        end
    endtask

    task automatic test_laps();
        logic [11:0] exp_slot[4] = '{12'h012, 12'h045, 12'h077, 12'h099};
        logic [7:0]  cnts[5]     = '{8'h12, 8'h45, 8'h77, 8'h99, 8'h00};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            {cnt_hi, cnt_lo} = cnts[k];
            if (k == 4) begin is_end = 1; tick(); is_end = 0; end
            lap_req = 1; tick(); lap_req = 0; tick();
            n_tests++;
            if (lap_count !== 3'((k < 4) ? k + 1 : 4)) begin
                n_fail++;
                $display("FAIL lap_count[%0d]: got %0d, need %0d", k, lap_count, (k < 4) ? k + 1 : 4);
            end
        end
        n_tests++;
        if (lap_full !== 1'b1 || hundreds !== 4'd1) begin
            n_fail++;
            $display("FAIL lap_full: got full=%b hund=%0d, need 1 1", lap_full, hundreds);
        end
        for (int s = 0; s < 4; s++) begin
            lap_sel = 2'(s); #1;
            n_tests++;
            if (lap_valid !== 1'b1 || {lap_hund, lap_hi, lap_lo} !== exp_slot[s]) begin
                n_fail++;
                $display("FAIL lap_slot[%0d]: got valid=%b %h, need 1 %h",
                         s, lap_valid, {lap_hund, lap_hi, lap_lo}, exp_slot[s]);
            end
        end
    endtask

    task automatic test_clr();
        do_reset();
        {cnt_hi, cnt_lo} = 8'h31;
        lap_req = 1; tick(); lap_req = 0; tick();
        lap_clr = 1; lap_req = 1; tick();
        lap_clr = 0; lap_req = 0;
        for (int s = 0; s < 4; s++) begin
            lap_sel = 2'(s); #1;
            n_tests++;
            if (lap_count !== 3'd0 || lap_valid !== 1'b0 || {lap_hund, lap_hi, lap_lo} !== 12'h0) begin
                n_fail++;
                $display("FAIL lap_clr[%0d]: got cnt=%0d valid=%b %h, need 0 0 000",
                         s, lap_count, lap_valid, {lap_hund, lap_hi, lap_lo});
            end
        end
    endtask

    task automatic test_reset_edge();
        reset = 1; is_end = 1; lap_req = 0; lap_clr = 0;
        tick(); tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (alarm !== 1'b0 || hundreds !== 4'd0) begin
                n_fail++;
                $display("FAIL held_end[%0d]: got alarm=%b hund=%0d, need 0 0", i, alarm, hundreds);
            end
        end
        is_end = 0; tick(); is_end = 1; tick(); is_end = 0; tick();
        reset = 1; tick();
        n_tests++;
        if (alarm !== 1'b0 || blink !== 1'b0 || hundreds !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_ring: got alarm=%b blink=%b hund=%0d, need 0 0 0", alarm, blink, hundreds);
        end
        reset = 0;
    endtask

    task automatic test_random();
        logic [11:0] exp_w;
        bit          exp_v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 79) == 0);
            is_end  = ($urandom_range(0, 4) == 0);
            lap_req = ($urandom_range(0, 2) == 0);
            lap_clr = ($urandom_range(0, 24) == 0);
            lap_sel = 2'($urandom_range(0, 3));
            cnt_hi  = 4'($urandom_range(0, 9));
            cnt_lo  = 4'($urandom_range(0, 9));
            tick();
            exp_v = (int'(lap_sel) < m_laps.size());
            exp_w = exp_v ? m_laps[lap_sel] : 12'h0;
            n_tests++;
            if (hundreds !== m_hund || alarm !== m_ring || blink !== (m_ring && m_el % 2 == 0) ||
                lap_count !== 3'(m_laps.size()) || lap_full !== (m_laps.size() == 4) ||
                lap_valid !== exp_v || {lap_hund, lap_hi, lap_lo} !== exp_w) begin
                n_fail++;
                $display("FAIL random[%0d]: got h=%0d a=%b b=%b cnt=%0d f=%b v=%b w=%h, need h=%0d a=%b b=%b cnt=%0d f=%b v=%b w=%h",
                         c, hundreds, alarm, blink, lap_count, lap_full, lap_valid, {lap_hund, lap_hi, lap_lo},
                         m_hund, m_ring, (m_ring && m_el % 2 == 0), m_laps.size(), (m_laps.size() == 4), exp_v, exp_w);
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_alarm();
        test_retrigger();
        test_hundreds_wrap();
        test_laps();
        test_clr();
        test_reset_edge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
